mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (1-cycle read latency) between the Fetch stage (instruction reads) and the store stage (data loads/stores) of the pipelined CPU.
- Grants at most one access per cycle, with load/store priority and a starvation bound for fetch.
- Returns read data to the requester with a registered valid strobe.
- Sits between the Fetch/DecodeExecute stages and the shared memory; the top level drives reset from the synchronised SW1.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_starve_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter and the CPU stages that use it.
// Holds read-owner encoding and default memory geometry.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating 4-bit fetch starvation counter; raises force_if once the count
// reaches STARVE_MAX so the next pending fetch wins over load/store.
module mem_port_arbiter_starve_counter #(
    parameter int STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       force_if
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != 4'hF)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign force_if = (cnt >= 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with
// load/store priority, bounded fetch starvation and a registered read return.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        starve_cnt
);

    logic   force_if;
    owner_e rd_owner_p0;
    owner_e rd_owner_p1;

    // Stage p0: combinational grant and RAM request in the request cycle
    always_comb begin
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rd_owner_p0 = OWN_NONE;
        if (!reset) begin
            if_gnt = if_req & (~ls_req | force_if);
            ls_gnt = ls_req & ~if_gnt;
        end
        if (if_gnt) begin
            mem_addr    = if_addr;
            rd_owner_p0 = OWN_IF;
        end else if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            if (!ls_we) begin
                rd_owner_p0 = OWN_LS;
            end
        end
    end

    assign mem_en = if_gnt | ls_gnt;
    assign mem_we = ls_gnt & ls_we;

    mem_port_arbiter_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (CLOCK_50),
        .reset   (reset),
        .inc     (if_req & ~if_gnt),
        .clr     (if_gnt | ~if_req),
        .cnt     (starve_cnt),
        .force_if(force_if)
    );

    // Stage p1: read data returns from the RAM one cycle after the grant
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_owner_p1 <= OWN_NONE;
        end else begin
            rd_owner_p1 <= rd_owner_p0;
        end
    end

    assign if_rvalid = (rd_owner_p1 == OWN_IF);
    assign ls_rvalid = (rd_owner_p1 == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  starve_cnt;

    logic [31:0] ram [256];
    int total = 0;
    int bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .starve_cnt(starve_cnt)
    );

    // RAM contents: word i holds 32'hA50000ii
    initial begin
        mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA5000000 | 32'(i);
    end

    always @(posedge CLOCK_50) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        if_req = 1; ls_req = 1;
        @(negedge CLOCK_50);
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_ls_gnt", 32'(ls_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        next_cycle();
        reset = 0; idle_inputs();
        @(negedge CLOCK_50);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_ls_rvalid", 32'(ls_rvalid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_starve", 32'(starve_cnt), 0);

        // Fetch only
        next_cycle();
        if_req = 1; if_addr = 8'h04;
        @(negedge CLOCK_50);
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_mem_en", 32'(mem_en), 1);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_mem_addr", 32'(mem_addr), 32'h04);
        next_cycle();
        idle_inputs();
        @(negedge CLOCK_50);
        chk("f_if_rvalid", 32'(if_rvalid), 1);
        chk("f_if_rdata", if_rdata, 32'hA5000004);
        chk("f_ls_rdata", ls_rdata, 0);

        // Contention: load wins three cycles, fetch forced on the fourth
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if_req = 1; if_addr = 8'h08; ls_req = 1; ls_we = 0; ls_addr = 8'h10;
            @(negedge CLOCK_50);
            chk("c_starve", 32'(starve_cnt), 32'(k));
            chk("c_ls_gnt", 32'(ls_gnt), (k < 3) ? 1 : 0);
            chk("c_if_gnt", 32'(if_gnt), (k < 3) ? 0 : 1);
            if (k > 0) chk("c_ls_rdata", ls_rdata, 32'hA5000010);
        end
        chk("c_mem_addr", 32'(mem_addr), 32'h08);
        next_cycle();
        idle_inputs();
        @(negedge CLOCK_50);
        chk("c_starve_clr", 32'(starve_cnt), 0);
        chk("c_if_rvalid", 32'(if_rvalid), 1);
        chk("c_if_rdata", if_rdata, 32'hA5000008);
        chk("c_ls_rvalid", 32'(ls_rvalid), 0);

        // Store then load back
        next_cycle();
        ls_req = 1; ls_we = 1; ls_addr = 8'h20; ls_wdata = 32'hDEADBEEF;
        @(negedge CLOCK_50);
        chk("s_ls_gnt", 32'(ls_gnt), 1);
        chk("s_mem_we", 32'(mem_we), 1);
        chk("s_mem_addr", 32'(mem_addr), 32'h20);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        ls_we = 0; ls_wdata = 0;
        @(negedge CLOCK_50);
        chk("s_no_rvalid", 32'(ls_rvalid), 0);
        chk("s_ld_mem_we", 32'(mem_we), 0);
        next_cycle();
        idle_inputs();
        @(negedge CLOCK_50);
        chk("s_ld_rvalid", 32'(ls_rvalid), 1);
        chk("s_ld_rdata", ls_rdata, 32'hDEADBEEF);

        // Back-to-back IF@0, LS@1, IF@2
        next_cycle();
        if_req = 1; if_addr = 8'h00;
        @(negedge CLOCK_50);
        chk("b_if_gnt0", 32'(if_gnt), 1);
        next_cycle();
        idle_inputs(); ls_req = 1; ls_addr = 8'h01;
        @(negedge CLOCK_50);
        chk("b_if_rvalid1", 32'(if_rvalid), 1);
        chk("b_if_rdata1", if_rdata, 32'hA5000000);
        chk("b_ls_rdata1", ls_rdata, 0);
        chk("b_ls_gnt1", 32'(ls_gnt), 1);
        next_cycle();
        idle_inputs(); if_req = 1; if_addr = 8'h02;
        @(negedge CLOCK_50);
        chk("b_ls_rvalid2", 32'(ls_rvalid), 1);
        chk("b_if_rvalid2", 32'(if_rvalid), 0);
        chk("b_ls_rdata2", ls_rdata, 32'hA5000001);
        chk("b_if_rdata2", if_rdata, 0);
        next_cycle();
        idle_inputs();
        @(negedge CLOCK_50);
        chk("b_if_rvalid3", 32'(if_rvalid), 1);
        chk("b_if_rdata3", if_rdata, 32'hA5000002);
        chk("b_ls_rdata3", ls_rdata, 0);

        // Reset in the request cycle drops the read and clears starvation
        next_cycle();
        if_req = 1; ls_req = 1; ls_addr = 8'h30;
        @(negedge CLOCK_50);
        chk("r_pre_ls_gnt", 32'(ls_gnt), 1);
        next_cycle();
        reset = 1; ls_addr = 8'h30;
        @(negedge CLOCK_50);
        chk("r_ls_gnt", 32'(ls_gnt), 0);
        chk("r_if_gnt", 32'(if_gnt), 0);
        chk("r_mem_en", 32'(mem_en), 0);
        next_cycle();
        reset = 0; idle_inputs();
        @(negedge CLOCK_50);
        chk("r_ls_rvalid", 32'(ls_rvalid), 0);
        chk("r_ls_rdata", ls_rdata, 0);
        chk("r_starve", 32'(starve_cnt), 0);

        // Idle for ten cycles
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge CLOCK_50);
            chk("i_mem_en", 32'(mem_en), 0);
            chk("i_mem_addr", 32'(mem_addr), 0);
            chk("i_gnt", {30'd0, if_gnt, ls_gnt}, 0);
            chk("i_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
            chk("i_starve", 32'(starve_cnt), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
